// File: rtl/dvp_if.sv
// dvp_if: DVP pad inputs and assembled-pixel outputs of the capture block
//   master: sensor/testbench side, drives vsync, href, d
//   slave : capture side, drives pix_data, pix_valid, sof, sol, eol, odd_err, line_len
interface dvp_if #(parameter int COL_W = 11);
    logic             vsync;
    logic             href;
    logic [7:0]       d;
    logic [15:0]      pix_data;
    logic             pix_valid;
    logic             sof;
    logic             sol;
    logic             eol;
    logic             odd_err;
    logic [COL_W-1:0] line_len;
    modport master (output vsync, href, d,
                    input  pix_data, pix_valid, sof, sol, eol, odd_err, line_len);
    modport slave  (input  vsync, href, d,
                    output pix_data, pix_valid, sof, sol, eol, odd_err, line_len);
endinterface

// File: rtl/dvp_capture.sv
// dvp_capture: DVP receive stage, pairs bytes into RGB565 pixels with frame/line markers
//   clk  : DVP pixel clock
//   rst  : synchronous reset, active high
//   bus  : dvp_if.slave (vsync/href/d in; pix_data/pix_valid/sof/sol/eol/odd_err/line_len out)
module dvp_capture #(
    parameter bit VSYNC_POL = 1'b1,
    parameter bit HREF_POL  = 1'b1,
    parameter int COL_W     = 11
) (
    input logic clk,
    input logic rst,
    dvp_if.slave bus
);
    typedef enum logic [1:0] {SYNC, VBLANK, ACTIVE, LINE} state_t;
    state_t           state;
    logic             vs_q, hr_q, phase, sof_arm, sol_arm;
    logic [7:0]       d_q, hi;
    logic [COL_W-1:0] col;
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SYNC;
            vs_q          <= 1'b0;
            hr_q          <= 1'b0;
            d_q           <= '0;
            hi            <= '0;
            phase         <= 1'b0;
            sof_arm       <= 1'b0;
            sol_arm       <= 1'b0;
            col           <= '0;
            bus.pix_data  <= '0;
            bus.pix_valid <= 1'b0;
            bus.sof       <= 1'b0;
            bus.sol       <= 1'b0;
            bus.eol       <= 1'b0;
            bus.odd_err   <= 1'b0;
            bus.line_len  <= '0;
        end else begin
            // polarity-normalised: 1 means blanking / line data active
            vs_q          <= bus.vsync == VSYNC_POL;
            hr_q          <= bus.href == HREF_POL;
            d_q           <= bus.d;
            bus.pix_valid <= 1'b0;
            bus.sof       <= 1'b0;
            bus.sol       <= 1'b0;
            bus.eol       <= 1'b0;
            bus.odd_err   <= 1'b0;
            case (state)
                SYNC:   if (vs_q) state <= VBLANK;
                VBLANK: if (!vs_q) begin
                    state   <= ACTIVE;
                    sof_arm <= 1'b1;
                end
                ACTIVE: if (vs_q) begin
                    state <= VBLANK;
                end else if (hr_q) begin
                    // the entry byte is the high byte of the first pixel
                    state   <= LINE;
                    hi      <= d_q;
                    phase   <= 1'b1;
                    col     <= '0;
                    sol_arm <= 1'b1;
                end
                LINE: if (vs_q) begin
                    // aborted line: drop pending byte, no eol, line_len untouched
                    state <= VBLANK;
                    phase <= 1'b0;
                end else if (hr_q) begin
                    if (!phase) begin
                        hi    <= d_q;
                        phase <= 1'b1;
                    end else begin
                        bus.pix_data  <= {hi, d_q};
                        bus.pix_valid <= 1'b1;
                        bus.sof       <= sof_arm;
                        bus.sol       <= sol_arm;
                        sof_arm       <= 1'b0;
                        sol_arm       <= 1'b0;
                        phase         <= 1'b0;
                        col           <= (&col) ? col : col + 1'b1;
                    end
                end else begin
                    state        <= ACTIVE;
                    bus.eol      <= 1'b1;
                    bus.odd_err  <= phase;
                    bus.line_len <= col;
                    phase        <= 1'b0;
                end
            endcase
        end
    end
endmodule
